serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 19 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 123 ++++++++++++
 tb/tb_serial_subtractor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional signed-overflow output is enabled with SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int SUB_WIDTH_DEFAULT = 4;
  localparam int SUB_CNT_W_DEFAULT = $clog2(SUB_WIDTH_DEFAULT);

  // Bit-counter width for a given operand width (WIDTH >= 2 keeps this >= 1).
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - b_in, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B - B_in behind a start/ready/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output OVF.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  output logic             ready,
  output logic [WIDTH-1:0] D,
  output logic             B_out,
  output logic             done,
  output state_e           dbg_state
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);

  // Handshake: start is sampled only on an edge where ready=1; ready is high
  // only in IDLE, done is a one-cycle pulse and never coincides with ready.
  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q, b_q, res_q, res_d;
  logic               borrow_q;
  logic [WIDTH-1:0]   d_q;
  logic               bout_q;
  logic               ready_q;
  logic               done_q;
  logic               fs_d, fs_bout;
  logic               last_bit;
`ifdef SERIAL_SUB_OVF_EN
  logic               ovf_q;
`endif

  full_subtractor u_fs (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .b_in  (borrow_q),
    .d     (fs_d),
    .b_out (fs_bout)
  );

  always_comb begin
    res_d    = {fs_d, res_q[WIDTH-1:1]};
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= B_in;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            state_q  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_q      <= {1'b0, a_q[WIDTH-1:1]};
          b_q      <= {1'b0, b_q[WIDTH-1:1]};
          res_q    <= res_d;
          borrow_q <= fs_bout;
          cnt_q    <= cnt_q + 1'b1;
          if (last_bit) begin
            d_q     <= res_d;
            bout_q  <= fs_bout;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit a_q[0]/b_q[0] hold the operand sign bits.
            ovf_q   <= (a_q[0] != b_q[0]) && (fs_d != a_q[0]);
`endif
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign D         = d_q;
  assign B_out     = bout_q;
  assign dbg_state = state_q;
`ifdef SERIAL_SUB_OVF_EN
  assign OVF       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH=4).
// OVF checks are compiled in only when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W = 4;

  // clock / reset
  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] A, B;
  logic         B_in;
  logic         ready, B_out, done;
  logic [W-1:0] D;
  state_e       dbg_state;
`ifdef SERIAL_SUB_OVF_EN
  logic         OVF;
`endif

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .A         (A),
    .B         (B),
    .B_in      (B_in),
    .ready     (ready),
    .D         (D),
    .B_out     (B_out),
    .done      (done),
    .dbg_state (dbg_state)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .OVF       (OVF)
`endif
  );

  // scoreboard counters
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ready and done must never be high together
  always @(negedge clk) begin
    if (reset === 1'b0 && ready === 1'b1 && done === 1'b1) begin
      total_cnt++;
      $display("FAIL ready_done_overlap: got ready=1 done=1 expected not both");
    end
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_d;
    logic         exp_bout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[$];
  logic [W-1:0] exp_q[$];

  // Drives one op starting from IDLE; returns results and edges from accept to done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output logic [W-1:0] d, output logic bo, output logic ov,
                        output int lat);
    @(negedge clk);
    check("ready_before_start", ready, 1'b1);
    A = a; B = b; B_in = bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 4'($urandom_range(0, 15)); B = 4'($urandom_range(0, 15));
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      check("ready_low_busy", ready, 1'b0);
      @(negedge clk);
      lat++;
    end
    d  = D;
    bo = B_out;
`ifdef SERIAL_SUB_OVF_EN
    ov = OVF;
`else
    ov = 1'b0;
`endif
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("ready_after_done", ready, 1'b1);
  endtask

  initial begin
    logic [W-1:0] d_got;
    logic         bo_got, ov_got;
    int           lat;
    logic         saw_done;

    reset = 1'b1; start = 1'b0; A = '0; B = '0; B_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_done",  done,  1'b0);
    check("rst_D",     D,     '0);
    check("rst_B_out", B_out, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_OVF",   OVF,   1'b0);
`endif
    reset = 1'b0;

    // a, b, b_in, D, B_out, OVF  (OVF = sign(A)!=sign(B) && sign(D)!=sign(A))
    vecs.push_back('{4'd9,  4'd3,  1'b0, 4'd6,  1'b0, 1'b1});
    vecs.push_back('{4'd3,  4'd9,  1'b0, 4'd10, 1'b1, 1'b1});
    vecs.push_back('{4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 1'b0});
    vecs.push_back('{4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1});
    vecs.push_back('{4'd7,  4'd15, 1'b0, 4'd8,  1'b1, 1'b1});
    vecs.push_back('{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0});
    vecs.push_back('{4'd5,  4'd5,  1'b0, 4'd0,  1'b0, 1'b0});
    vecs.push_back('{4'd15, 4'd0,  1'b0, 4'd15, 1'b0, 1'b0});
    vecs.push_back('{4'd0,  4'd15, 1'b0, 4'd1,  1'b1, 1'b0});
    vecs.push_back('{4'd6,  4'd2,  1'b1, 4'd3,  1'b0, 1'b0});
    vecs.push_back('{4'd10, 4'd12, 1'b1, 4'd13, 1'b1, 1'b0});

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, d_got, bo_got, ov_got, lat);
      check($sformatf("v%0d_latency", i), lat, W);
      check($sformatf("v%0d_D", i), d_got, vecs[i].exp_d);
      check($sformatf("v%0d_B_out", i), bo_got, vecs[i].exp_bout);
`ifdef SERIAL_SUB_OVF_EN
      check($sformatf("v%0d_OVF", i), ov_got, vecs[i].exp_ovf);
`endif
    end

    // reset mid-SHIFT: sampled at E2 of an op (last D was 13 from the table)
    @(negedge clk);
    A = 4'd9; B = 4'd3; B_in = 1'b0; start = 1'b1;
    @(negedge clk);            // after E0
    start = 1'b0;
    @(negedge clk);            // after E1
    reset = 1'b1;
    @(negedge clk);            // after E2
    reset = 1'b0;
    check("midrst_ready", ready, 1'b1);
    check("midrst_D",     D,     '0);
    check("midrst_B_out", B_out, 1'b0);
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 1'b0);
    run_op(4'd12, 4'd5, 1'b0, d_got, bo_got, ov_got, lat);
    check("postrst_latency", lat, W);
    check("postrst_D", d_got, 4'd7);
    check("postrst_B_out", bo_got, 1'b0);

    // start held high: accepts at E0 and E6; operands scrambled while busy
    exp_q.push_back(4'd6);
    exp_q.push_back(4'd10);
    @(negedge clk);
    A = 4'd9; B = 4'd3; B_in = 1'b0; start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);          // after E_k
      check($sformatf("b2b_done_k%0d", k), done, (k == 4 || k == 10));
      check($sformatf("b2b_ready_k%0d", k), ready, (k == 5 || k == 11));
      if (done === 1'b1) begin
        if (exp_q.size() > 0) check($sformatf("b2b_D_k%0d", k), D, exp_q.pop_front());
        else check("b2b_extra_done", 1'b1, 1'b0);
      end
      if (k == 5) begin
        A = 4'd3; B = 4'd9;
      end else if (k == 11) begin
        start = 1'b0;
      end else begin
        A = 4'($urandom_range(0, 15)); B = 4'($urandom_range(0, 15));
      end
    end
    check("b2b_all_results", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
